ioctl_upload_reader: RTL and testbench
======================================

IOCTL_UPLOAD_READER -- requirements
Module: ioctl_upload_reader

Interface
REQ-001 SHALL have parameter RAM_AW, default 11, the work-RAM byte-address width.
REQ-002 SHALL have parameter NREG, default 2, the number of upload regions; fixed at 2.
REQ-003 SHALL have port clk_sys  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port cfg_wr  in  1  region-table write strobe.
REQ-006 SHALL have port cfg_idx  in  1  region index to write.
REQ-007 SHALL have port cfg_start  in  RAM_AW  region start address in work RAM.
REQ-008 SHALL have port cfg_len  in  8  region length minus 1, in bytes.
REQ-009 SHALL have port save_trigger  in  1  autosave request pulse.
REQ-010 SHALL have port upload_req  out  1  one-cycle request for an HPS upload.
REQ-011 SHALL have port ioctl_upload  in  1  high while the HPS upload is active.
REQ-012 SHALL have port ioctl_rd  in  1  one-cycle byte read strobe from the HPS.
REQ-013 SHALL have port ioctl_addr  in  25  linear byte offset into the upload stream.
REQ-014 SHALL have port ioctl_din  out  8  byte returned to the HPS.
REQ-015 SHALL have port pause_req  out  1  CPU pause request.
REQ-016 SHALL have port paused  in  1  pause acknowledge from the CPU.
REQ-017 SHALL have port ram_rd  out  1  work-RAM read strobe.
REQ-018 SHALL have port ram_addr  out  RAM_AW  work-RAM read address.
REQ-019 SHALL have port ram_dout  in  8  work-RAM data, valid 1 cycle after ram_rd.
REQ-020 SHALL have port configured  out  1  high when at least one region has been written.

Function
REQ-021 SHALL implement a state machine with states IDLE, PAUSE_WAIT, READY, RD_ISSUE, RD_CAP and RELEASE.
REQ-022 IDLE SHALL go to PAUSE_WAIT when ioctl_upload rises, and SHALL assert pause_req from the following cycle.
REQ-023 PAUSE_WAIT SHALL go to READY on the first cycle in which paused=1.
REQ-024 An ioctl_rd received in IDLE or PAUSE_WAIT SHALL be held in a pending flag together with its address.
REQ-025 On entry to READY, the pending read SHALL be served as if its ioctl_rd arrived in that cycle.
REQ-026 On ioctl_rd in READY, the block SHALL go to RD_ISSUE, map the offset to a RAM address and pulse ram_rd for 1 cycle.
REQ-027 Offset mapping: off < len0+1 maps to start0+off; otherwise off-(len0+1) < len1+1 maps to start1+off-(len0+1); address addition SHALL wrap modulo 2^RAM_AW.
REQ-028 An offset beyond the total length, or any offset while configured=0, SHALL assert no ram_rd and SHALL return 0x00.
REQ-029 RD_CAP SHALL register ram_dout into ioctl_din, so ioctl_din is valid 2 cycles after ioctl_rd and is held until the next capture.
REQ-030 A second ioctl_rd that arrives while in RD_ISSUE or RD_CAP SHALL be pending and SHALL be served on return to READY; no read is dropped.
REQ-031 A fall of ioctl_upload in any non-IDLE state SHALL go to RELEASE after any in-flight capture completes.
REQ-032 RELEASE SHALL deassert pause_req and clear the pending flag, then go to IDLE after 1 cycle.
REQ-033 save_trigger SHALL produce a one-cycle upload_req only when configured=1, the state is IDLE and ioctl_upload=0; otherwise it SHALL be ignored.
REQ-034 A cfg_wr received outside IDLE SHALL be ignored, so the table is stable during an upload.
REQ-035 When cfg_wr and save_trigger occur in the same cycle, the table SHALL be written and upload_req SHALL be evaluated against the old configured value.

Reset
REQ-036 On reset_n=0 the block SHALL immediately enter IDLE.
REQ-037 On reset_n=0 the block SHALL clear the pending flag and force configured, upload_req, pause_req and ram_rd to 0.
REQ-038 On reset_n=0 the block SHALL force ram_addr to 0, ioctl_din to 0x00, and clear both region entries to start 0, len 0, invalid.
REQ-039 A reset asserted mid-upload SHALL release pause_req asynchronously.

Structure
REQ-040 A shared package SHALL hold the state enumeration, the region record type (start, len, valid) and the constant RAM_AW_DEFAULT.
REQ-041 The offset-to-address mapping SHALL be one combinational sub-module named ioctl_region_map.

Verification
REQ-042 Configure region0 start 0x100 len 0x0F and region1 start 0x7F8 len 0x0F, then upload offsets 0..31 -> RAM addresses 0x100..0x10F then 0x7F8..0x7FF, 0x000..0x007, with matching bytes.
REQ-043 Issue ioctl_rd before paused rises, with paused delayed by 10 cycles -> exactly one ram_rd after paused, and correct ioctl_din 2 cycles later.
REQ-044 Read offset 40 with total length 32 -> no ram_rd, and ioctl_din = 0x00.
REQ-045 Issue ioctl_rd strobes back-to-back on consecutive cycles -> both served in order, ioctl_din shows each byte in turn, and nothing is dropped.
REQ-046 Pulse save_trigger with configured=0, then with configured=1 during an upload, then in IDLE -> upload_req only on the last pulse.
REQ-047 Drop reset_n during RD_CAP -> pause_req=0 and ioctl_din=0x00 immediately, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/ioctl_upload_reader_pkg.sv
// Shared types for the HPS upload reader: FSM states, region table entries and
// the helper that turns a region entry into its size in bytes.
package ioctl_upload_reader_pkg;

    localparam int RAM_AW_DEFAULT = 11;
    localparam int RAM_AW_MAX     = 16;
    localparam int OFF_W          = 25;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PAUSE_WAIT = 3'd1,
        S_READY      = 3'd2,
        S_RD_ISSUE   = 3'd3,
        S_RD_CAP     = 3'd4,
        S_RELEASE    = 3'd5
    } state_e;

    // start is stored at the widest supported RAM width; users take the low RAM_AW bits.
    typedef struct packed {
        logic [RAM_AW_MAX-1:0] start;
        logic [7:0]            len;
        logic                  valid;
    } region_t;

    localparam region_t REGION_RESET = '{start: {RAM_AW_MAX{1'b0}}, len: 8'h00, valid: 1'b0};

    // An unwritten region contributes no bytes to the upload stream.
    function automatic logic [8:0] region_size(input logic valid, input logic [7:0] len);
        logic [8:0] size;
        if (valid) begin
            size = {1'b0, len} + 9'd1;
        end else begin
            size = 9'd0;
        end
        return size;
    endfunction

endpackage

// File: rtl/ioctl_region_map.sv
// Combinational map from a linear upload offset to a work-RAM byte address,
// walking region0 then region1; address sums wrap at the RAM size.
module ioctl_region_map
    import ioctl_upload_reader_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT
) (
    input  logic [RAM_AW-1:0] start0_i,
    input  logic [7:0]        len0_i,
    input  logic              valid0_i,
    input  logic [RAM_AW-1:0] start1_i,
    input  logic [7:0]        len1_i,
    input  logic              valid1_i,
    input  logic [OFF_W-1:0]  offset_i,
    output logic              hit_o,
    output logic [RAM_AW-1:0] addr_o
);

    logic [8:0]       size0_s;
    logic [8:0]       size1_s;
    logic [OFF_W-1:0] rel1_s;
    logic             in0_s;
    logic             in1_s;

    // Region select and address sum for the requested offset.
    always_comb begin
        size0_s = region_size(valid0_i, len0_i);
        size1_s = region_size(valid1_i, len1_i);
        rel1_s  = offset_i - {16'd0, size0_s};
        in0_s   = (offset_i < {16'd0, size0_s});
        in1_s   = !in0_s && (rel1_s < {16'd0, size1_s});
        hit_o   = in0_s | in1_s;
        if (in0_s) begin
            addr_o = start0_i + offset_i[RAM_AW-1:0];
        end else if (in1_s) begin
            addr_o = start1_i + rel1_s[RAM_AW-1:0];
        end else begin
            addr_o = {RAM_AW{1'b0}};
        end
    end

endmodule

// File: rtl/ioctl_upload_reader.sv
// Serves HPS upload byte reads from a two-region table in CPU work RAM,
// pausing the CPU for the duration of the upload.
module ioctl_upload_reader
    import ioctl_upload_reader_pkg::*;
#(
    parameter int RAM_AW = RAM_AW_DEFAULT,
    parameter int NREG   = 2
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic              cfg_idx,
    input  logic [RAM_AW-1:0] cfg_start,
    input  logic [7:0]        cfg_len,
    input  logic              save_trigger,
    output logic              upload_req,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              pause_req,
    input  logic              paused,
    output logic              ram_rd,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [7:0]        ram_dout,
    output logic              configured
);

    state_e            state_q, state_d;
    logic              upload_q;
    logic              pend_q, pend_d;
    logic [OFF_W-1:0]  pend_addr_q, pend_addr_d;
    logic              miss_q, miss_d;
    logic              ram_rd_q, ram_rd_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]        din_q, din_d;
    logic              pause_q, pause_d;
    logic              upload_req_q, upload_req_d;
    logic              configured_q, configured_d;
    region_t           region0_q, region0_d;
    region_t           region1_q, region1_d;

    region_t           cfg_entry_s;
    logic [NREG-1:0]   region_valid_s;
    logic              serve_s;
    logic [OFF_W-1:0]  serve_addr_s;
    logic              map_hit_s;
    logic [RAM_AW-1:0] map_addr_s;
    logic              unused_start_s;

    assign cfg_entry_s    = '{start: RAM_AW_MAX'(cfg_start), len: cfg_len, valid: 1'b1};
    assign region_valid_s = {region1_d.valid, region0_d.valid};
    assign configured_d   = |region_valid_s;
    // A held read is older than one arriving now, so it is served first.
    assign serve_s        = pend_q | ioctl_rd;
    assign serve_addr_s   = pend_q ? pend_addr_q : ioctl_addr;
    assign pause_d        = (state_d == S_PAUSE_WAIT) || (state_d == S_READY) ||
                            (state_d == S_RD_ISSUE)   || (state_d == S_RD_CAP);
    assign unused_start_s = ^{region0_q.start, region1_q.start};

    ioctl_region_map #(
        .RAM_AW (RAM_AW)
    ) u_map (
        .start0_i (region0_q.start[RAM_AW-1:0]),
        .len0_i   (region0_q.len),
        .valid0_i (region0_q.valid),
        .start1_i (region1_q.start[RAM_AW-1:0]),
        .len1_i   (region1_q.len),
        .valid1_i (region1_q.valid),
        .offset_i (serve_addr_s),
        .hit_o    (map_hit_s),
        .addr_o   (map_addr_s)
    );

    // Next-state logic: FSM, single-entry pending read slot, region table and output registers.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_addr_d  = pend_addr_q;
        miss_d       = miss_q;
        ram_rd_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        din_d        = din_q;
        upload_req_d = 1'b0;
        region0_d    = region0_q;
        region1_d    = region1_q;

        case (state_q)
            S_IDLE: begin
                if (ioctl_rd) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ioctl_addr;
                end else begin
                    pend_d      = pend_q;
                end
                if (cfg_wr) begin
                    if (cfg_idx) begin
                        region1_d = cfg_entry_s;
                    end else begin
                        region0_d = cfg_entry_s;
                    end
                end else begin
                    region0_d = region0_q;
                end
                // configured_q is the pre-write value, so a same-cycle first write cannot trigger.
                upload_req_d = save_trigger & configured_q & ~ioctl_upload;
                if (ioctl_upload && !upload_q) begin
                    state_d = S_PAUSE_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PAUSE_WAIT: begin
                if (ioctl_rd) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ioctl_addr;
                end else begin
                    pend_d      = pend_q;
                end
                if (!ioctl_upload) begin
                    state_d = S_RELEASE;
                end else if (paused) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_PAUSE_WAIT;
                end
            end
            S_READY: begin
                if (!ioctl_upload) begin
                    state_d = S_RELEASE;
                end else if (serve_s) begin
                    state_d     = S_RD_ISSUE;
                    pend_d      = pend_q & ioctl_rd;
                    pend_addr_d = ioctl_rd ? ioctl_addr : pend_addr_q;
                    if (map_hit_s && configured_q) begin
                        ram_rd_d   = 1'b1;
                        ram_addr_d = map_addr_s;
                        miss_d     = 1'b0;
                    end else begin
                        miss_d     = 1'b1;
                    end
                end else begin
                    state_d = S_READY;
                end
            end
            S_RD_ISSUE: begin
                if (ioctl_rd) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ioctl_addr;
                end else begin
                    pend_d      = pend_q;
                end
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                if (ioctl_rd) begin
                    pend_d      = 1'b1;
                    pend_addr_d = ioctl_addr;
                end else begin
                    pend_d      = pend_q;
                end
                din_d = miss_q ? 8'h00 : ram_dout;
                if (ioctl_upload) begin
                    state_d = S_READY;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                pend_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset also drops pause_req without waiting for a clock.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            upload_q     <= 1'b0;
            pend_q       <= 1'b0;
            pend_addr_q  <= {OFF_W{1'b0}};
            miss_q       <= 1'b0;
            ram_rd_q     <= 1'b0;
            ram_addr_q   <= {RAM_AW{1'b0}};
            din_q        <= 8'h00;
            pause_q      <= 1'b0;
            upload_req_q <= 1'b0;
            configured_q <= 1'b0;
            region0_q    <= REGION_RESET;
            region1_q    <= REGION_RESET;
        end else begin
            state_q      <= state_d;
            upload_q     <= ioctl_upload;
            pend_q       <= pend_d;
            pend_addr_q  <= pend_addr_d;
            miss_q       <= miss_d;
            ram_rd_q     <= ram_rd_d;
            ram_addr_q   <= ram_addr_d;
            din_q        <= din_d;
            pause_q      <= pause_d;
            upload_req_q <= upload_req_d;
            configured_q <= configured_d;
            region0_q    <= region0_d;
            region1_q    <= region1_d;
        end
    end

    assign upload_req = upload_req_q;
    assign ioctl_din  = din_q;
    assign pause_req  = pause_q;
    assign ram_rd     = ram_rd_q;
    assign ram_addr   = ram_addr_q;
    assign configured = configured_q;

endmodule

// File: tb/tb_ioctl_upload_reader.sv
// Directed bench for ioctl_upload_reader with a work-RAM model and scoreboard queues.
module tb_ioctl_upload_reader;

    localparam int AW = 11;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          cfg_wr;
    logic          cfg_idx;
    logic [AW-1:0] cfg_start;
    logic [7:0]    cfg_len;
    logic          save_trigger;
    logic          upload_req;
    logic          ioctl_upload;
    logic          ioctl_rd;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_din;
    logic          pause_req;
    logic          paused;
    logic          ram_rd;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_dout = 8'h00;
    logic          configured;

    int checks = 0;
    int errors = 0;
    int upload_req_cnt = 0;

    logic [7:0] mem [0:2047];
    int         exp_addr_q[$];
    int         obs_addr_q[$];
    logic [7:0] exp_din_q[$];

    int m_st0, m_len0, m_st1, m_len1;
    bit m_v0, m_v1;

    ioctl_upload_reader #(.RAM_AW(AW), .NREG(2)) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .cfg_wr       (cfg_wr),
        .cfg_idx      (cfg_idx),
        .cfg_start    (cfg_start),
        .cfg_len      (cfg_len),
        .save_trigger (save_trigger),
        .upload_req   (upload_req),
        .ioctl_upload (ioctl_upload),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .pause_req    (pause_req),
        .paused       (paused),
        .ram_rd       (ram_rd),
        .ram_addr     (ram_addr),
        .ram_dout     (ram_dout),
        .configured   (configured)
    );

    always #5 clk_sys = ~clk_sys;

    // Work RAM: data appears one cycle after the read strobe.
    always @(posedge clk_sys) begin
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    // Observe RAM reads and upload requests mid-cycle.
    always @(negedge clk_sys) begin
        if (ram_rd) obs_addr_q.push_back(int'(ram_addr));
        if (upload_req) upload_req_cnt <= upload_req_cnt + 1;
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_map(input int off, output bit hit, output int addr);
        int sz0, sz1;
        sz0  = m_v0 ? m_len0 + 1 : 0;
        sz1  = m_v1 ? m_len1 + 1 : 0;
        hit  = 1'b0;
        addr = 0;
        if (off < sz0) begin
            hit  = 1'b1;
            addr = (m_st0 + off) % 2048;
        end else if (off - sz0 < sz1) begin
            hit  = 1'b1;
            addr = (m_st1 + off - sz0) % 2048;
        end
    endfunction

    task automatic expect_read(input int off);
        bit hit;
        int addr;
        model_map(off, hit, addr);
        if (hit) begin
            exp_addr_q.push_back(addr);
            exp_din_q.push_back(mem[addr]);
        end else begin
            exp_din_q.push_back(8'h00);
        end
    endtask

    task automatic compare_ram(input string tag);
        check({tag, "_count"}, 32'(obs_addr_q.size()), 32'(exp_addr_q.size()));
        while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
            check(tag, 32'(obs_addr_q.pop_front()), 32'(exp_addr_q.pop_front()));
        end
        obs_addr_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic check_din(input string tag);
        logic [7:0] e;
        e = exp_din_q.pop_front();
        check(tag, 32'(ioctl_din), 32'(e));
    endtask

    task automatic do_read(input int off);
        expect_read(off);
        ioctl_addr = 25'(off);
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        tick();
        check_din($sformatf("din_off%0d", off));
        compare_ram($sformatf("ram_addr_off%0d", off));
    endtask

    task automatic cfg_write(input logic idx, input int st, input int len, input logic trig);
        cfg_idx      = idx;
        cfg_start    = AW'(st);
        cfg_len      = 8'(len);
        cfg_wr       = 1'b1;
        save_trigger = trig;
        tick();
        cfg_wr       = 1'b0;
        save_trigger = 1'b0;
    endtask

    task automatic pulse_save();
        save_trigger = 1'b1;
        tick();
        save_trigger = 1'b0;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'(((i * 13 + 7) % 255) + 1);
        reset_n = 1'b0; cfg_wr = 1'b0; cfg_idx = 1'b0; cfg_start = '0; cfg_len = 8'h00;
        save_trigger = 1'b0; ioctl_upload = 1'b0; ioctl_rd = 1'b0; ioctl_addr = 25'd0; paused = 1'b0;
        m_v0 = 1'b0; m_v1 = 1'b0; m_st0 = 0; m_len0 = 0; m_st1 = 0; m_len1 = 0;
        repeat (3) tick();
        check("rst_configured", 32'(configured), 32'd0);
        check("rst_upload_req", 32'(upload_req), 32'd0);
        check("rst_pause_req", 32'(pause_req), 32'd0);
        check("rst_ram_rd", 32'(ram_rd), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'd0);
        check("rst_ioctl_din", 32'(ioctl_din), 32'd0);
        reset_n = 1'b1;
        tick();

        // save_trigger while unconfigured, then in the same cycle as the first table write
        pulse_save();
        check("upreq_unconfigured", 32'(upload_req_cnt), 32'd0);
        cfg_write(1'b0, 'h100, 'h0F, 1'b1);
        m_st0 = 'h100; m_len0 = 'h0F; m_v0 = 1'b1;
        tick();
        check("upreq_same_cycle_cfg", 32'(upload_req_cnt), 32'd0);
        check("configured_set", 32'(configured), 32'd1);
        cfg_write(1'b1, 'h7F8, 'h0F, 1'b0);
        m_st1 = 'h7F8; m_len1 = 'h0F; m_v1 = 1'b1;

        // upload starts; read arrives before the CPU acknowledges the pause
        ioctl_upload = 1'b1;
        tick();
        check("pause_req_on", 32'(pause_req), 32'd1);
        expect_read(5);
        ioctl_addr = 25'd5;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        repeat (10) tick();
        check("no_ram_rd_before_paused", 32'(obs_addr_q.size()), 32'd0);
        paused = 1'b1;
        repeat (4) tick();
        check_din("din_pending");
        compare_ram("ram_addr_pending");

        // save_trigger and cfg_wr during the upload are ignored
        pulse_save();
        check("upreq_during_upload", 32'(upload_req_cnt), 32'd0);
        cfg_write(1'b0, 'h200, 'h03, 1'b0);

        for (int off = 0; off < 32; off++) do_read(off);
        do_read(32);
        do_read(40);

        // back-to-back strobes: second is held and served after the first capture
        expect_read(3);
        expect_read(20);
        ioctl_addr = 25'd3;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_addr = 25'd20;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        check_din("din_b2b_first");
        repeat (3) tick();
        check_din("din_b2b_second");
        compare_ram("ram_addr_b2b");

        // normal end of upload, then an autosave request from IDLE
        ioctl_upload = 1'b0;
        tick();
        check("pause_req_released", 32'(pause_req), 32'd0);
        tick();
        paused = 1'b0;
        pulse_save();
        check("upreq_idle", 32'(upload_req_cnt), 32'd1);

        // reset asserted while a capture is in flight
        ioctl_upload = 1'b1;
        paused       = 1'b1;
        tick();
        tick();
        ioctl_addr = 25'd2;
        ioctl_rd   = 1'b1;
        tick();
        ioctl_rd   = 1'b0;
        tick();
        check("pause_req_before_reset", 32'(pause_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("async_pause_req", 32'(pause_req), 32'd0);
        check("async_ioctl_din", 32'(ioctl_din), 32'd0);
        ioctl_upload = 1'b0;
        paused       = 1'b0;
        m_v0 = 1'b0; m_v1 = 1'b0;
        tick();
        reset_n = 1'b1;
        obs_addr_q.delete();
        tick();
        check("post_rst_configured", 32'(configured), 32'd0);
        pulse_save();
        check("upreq_post_rst_unconfigured", 32'(upload_req_cnt), 32'd1);
        cfg_write(1'b1, 'h040, 'h07, 1'b0);
        tick();
        pulse_save();
        check("upreq_post_rst_idle", 32'(upload_req_cnt), 32'd2);
        check("post_rst_no_ram_rd", 32'(obs_addr_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
